// File: rtl/demo_avalon_arbiter_2m.sv
// demo_avalon_arbiter_2m
//   Two-master round-robin arbiter in front of one Avalon-MM slave.
//   A granted master owns the slave bus until the slave accepts its command.
//   Reads accepted by the slave push the issuing master's id into a tag FIFO,
//   so each s_readdatavalid is steered back to the master that asked for it.
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   m0_* / m1_*       : Avalon-MM master-side ports (commands in, stall/data out)
//   s_*               : Avalon-MM slave-side port (commands out, stall/data in)
//   pending_cnt       : reads accepted by the slave and not yet returned
//   err_unexp_rdv     : sticky, readdatavalid seen with no read outstanding
module demo_avalon_arbiter_2m #(
  parameter int AV_ADDRESS_W  = 16,
  parameter int AV_DATA_W     = 32,
  parameter int AV_NUMSYMBOLS = 4,
  parameter int MAX_PENDING   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          m0_write,
  input  logic                          m0_read,
  input  logic [AV_ADDRESS_W-1:0]       m0_address,
  input  logic [AV_NUMSYMBOLS-1:0]      m0_byteenable,
  input  logic [AV_DATA_W-1:0]          m0_writedata,
  output logic                          m0_waitrequest,
  output logic [AV_DATA_W-1:0]          m0_readdata,
  output logic                          m0_readdatavalid,
  input  logic                          m1_write,
  input  logic                          m1_read,
  input  logic [AV_ADDRESS_W-1:0]       m1_address,
  input  logic [AV_NUMSYMBOLS-1:0]      m1_byteenable,
  input  logic [AV_DATA_W-1:0]          m1_writedata,
  output logic                          m1_waitrequest,
  output logic [AV_DATA_W-1:0]          m1_readdata,
  output logic                          m1_readdatavalid,
  output logic                          s_write,
  output logic                          s_read,
  output logic [AV_ADDRESS_W-1:0]       s_address,
  output logic [AV_NUMSYMBOLS-1:0]      s_byteenable,
  output logic [AV_DATA_W-1:0]          s_writedata,
  input  logic                          s_waitrequest,
  input  logic [AV_DATA_W-1:0]          s_readdata,
  input  logic                          s_readdatavalid,
  output logic [$clog2(MAX_PENDING):0]  pending_cnt,
  output logic                          err_unexp_rdv
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic                   last_q, last_d;      // master granted by the last accepted transfer
  logic [MAX_PENDING-1:0] tag_q;               // issuing master id per outstanding read
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         cnt_q;
  logic                   err_q;

  logic req0, req1, fifo_full, fifo_empty;
  logic sel, g_wr, g_rd, g_wait, accept, push, pop;

  assign req0       = m0_write | m0_read;
  assign req1       = m1_write | m1_read;
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);

  // Granted master's strobes; a simultaneous write+read is treated as a write.
  assign sel  = (state_q == GNT1);
  assign g_wr = sel ? m1_write : m0_write;
  assign g_rd = (sel ? m1_read : m0_read) & ~g_wr;

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    push           = 1'b0;
    accept         = 1'b0;
    g_wait         = 1'b1;
    s_write        = 1'b0;
    s_read         = 1'b0;
    s_address      = '0;
    s_byteenable   = '0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      IDLE: begin
        // Tie goes to the master that did not win last time.
        if (req0 & req1)  state_d = last_q ? GNT0 : GNT1;
        else if (req0)    state_d = GNT0;
        else if (req1)    state_d = GNT1;
      end
      GNT0, GNT1: begin
        s_address    = sel ? m1_address    : m0_address;
        s_byteenable = sel ? m1_byteenable : m0_byteenable;
        s_writedata  = sel ? m1_writedata  : m0_writedata;
        s_write      = g_wr;
        // A read with no free tag slot is held off the slave bus entirely.
        s_read       = g_rd & ~fifo_full;
        g_wait       = s_waitrequest | (g_rd & fifo_full);
        if (sel) m1_waitrequest = g_wait;
        else     m0_waitrequest = g_wait;
        accept = (s_write | s_read) & ~s_waitrequest;
        if (!(g_wr | g_rd)) begin
          // Master dropped its request mid-grant: release without a transfer.
          state_d = IDLE;
        end else if (accept) begin
          state_d = IDLE;
          last_d  = sel;
          push    = s_read;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop              = s_readdatavalid & ~fifo_empty;
  assign m0_readdatavalid = pop & ~tag_q[rd_ptr_q];
  assign m1_readdatavalid = pop &  tag_q[rd_ptr_q];
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign pending_cnt      = cnt_q;
  assign err_unexp_rdv    = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (push) begin
        tag_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (s_readdatavalid & fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demo_avalon_arbiter_2m.sv
// Bench for demo_avalon_arbiter_2m: directed scenarios with literal checks,
// plus a transaction-level model (bus owner + queue of outstanding read
// owners) compared against the DUT on every cycle out of reset.
module tb_demo_avalon_arbiter_2m;
  localparam int AW = 16, DW = 32, NS = 4, MP = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic          mw[2], mr[2];
  logic [AW-1:0] ma[2];
  logic [NS-1:0] mbe[2];
  logic [DW-1:0] mwd[2];
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          s_write, s_read, s_waitrequest, s_readdatavalid;
  logic [AW-1:0] s_address;
  logic [NS-1:0] s_byteenable;
  logic [DW-1:0] s_writedata, s_readdata;
  logic [2:0]    pending_cnt;
  logic          err_unexp_rdv;

  int n_chk = 0, n_fail = 0;
  int gorder[$];

  always #5 clk = ~clk;

  demo_avalon_arbiter_2m #(.AV_ADDRESS_W(AW), .AV_DATA_W(DW), .AV_NUMSYMBOLS(NS), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset),
    .m0_write(mw[0]), .m0_read(mr[0]), .m0_address(ma[0]), .m0_byteenable(mbe[0]),
    .m0_writedata(mwd[0]), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_write(mw[1]), .m1_read(mr[1]), .m1_address(ma[1]), .m1_byteenable(mbe[1]),
    .m1_writedata(mwd[1]), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_write(s_write), .s_read(s_read), .s_address(s_address), .s_byteenable(s_byteenable),
    .s_writedata(s_writedata), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .pending_cnt(pending_cnt), .err_unexp_rdv(err_unexp_rdv)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int  own;        // -1: nobody owns the slave bus
  int  lastg;
  int  pq[$];      // owners of reads accepted but not yet returned
  bit  merr;

  always @(posedge clk) begin
    bit full, wr, rd, r0, r1, do_push;
    int nown;
    if (reset) begin
      own = -1; lastg = 1; pq.delete(); merr = 0;
    end else begin
      full = (pq.size() == MP);
      nown = own;
      do_push = 0;
      if (own < 0) begin
        r0 = mw[0] | mr[0];
        r1 = mw[1] | mr[1];
        if (r0 && r1)  nown = (lastg == 1) ? 0 : 1;
        else if (r0)   nown = 0;
        else if (r1)   nown = 1;
      end else begin
        wr = mw[own];
        rd = mr[own] && !wr;
        if (!(wr || rd)) nown = -1;
        else if ((wr || (rd && !full)) && !s_waitrequest) begin
          lastg = own; do_push = !wr; nown = -1;
        end
      end
      if (s_readdatavalid) begin
        if (pq.size() > 0) void'(pq.pop_front());
        else merr = 1;
      end
      if (do_push) pq.push_back(own);
      own = nown;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic e_w0, e_w1, e_sw, e_sr, e_r0, e_r1, rd, full;
    logic [AW-1:0] e_a; logic [NS-1:0] e_be; logic [DW-1:0] e_wd;
    if (!reset) begin
      full = (pq.size() == MP);
      e_w0 = 1; e_w1 = 1; e_sw = 0; e_sr = 0; e_a = '0; e_be = '0; e_wd = '0;
      if (own >= 0) begin
        rd   = mr[own] && !mw[own];
        e_sw = mw[own];
        e_sr = rd && !full;
        e_a  = ma[own]; e_be = mbe[own]; e_wd = mwd[own];
        if (own == 0) e_w0 = s_waitrequest || (rd && full);
        else          e_w1 = s_waitrequest || (rd && full);
      end
      e_r0 = s_readdatavalid && pq.size() > 0 && pq[0] == 0;
      e_r1 = s_readdatavalid && pq.size() > 0 && pq[0] == 1;
      chk("m_m0_wait", m0_waitrequest, e_w0);
      chk("m_m1_wait", m1_waitrequest, e_w1);
      chk("m_s_write", s_write, e_sw);
      chk("m_s_read", s_read, e_sr);
      chk("m_s_addr", s_address, e_a);
      chk("m_s_be", s_byteenable, e_be);
      chk("m_s_wdata", s_writedata, e_wd);
      chk("m_m0_rdv", m0_readdatavalid, e_r0);
      chk("m_m1_rdv", m1_readdatavalid, e_r1);
      chk("m_rdata", {m1_readdata, m0_readdata}, {s_readdata, s_readdata});
      chk("m_pending", pending_cnt, pq.size());
      chk("m_err", err_unexp_rdv, merr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_wait"}, {m1_waitrequest, m0_waitrequest}, 2'b11);
    chk({nm, "_rdv"}, {m1_readdatavalid, m0_readdatavalid}, 2'b00);
    chk({nm, "_cmd"}, {s_write, s_read}, 2'b00);
    chk({nm, "_bus"}, {s_address, s_byteenable, s_writedata}, 52'h0);
    chk({nm, "_pend"}, pending_cnt, 0);
    chk({nm, "_err"}, err_unexp_rdv, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      mw[i] = 0; mr[i] = 0; ma[i] = '0; mbe[i] = '0; mwd[i] = '0;
    end
    s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
    nxt();
    @(negedge clk);
    chk_reset_outs("rst");
    nxt();
    reset = 0;
    gorder.delete();
  endtask

  // Issue one transfer from master m and hold it until the slave accepts.
  task automatic xfer(input int m, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n; bit done;
    n = 0; done = 0;
    mw[m] = wr; mr[m] = !wr; ma[m] = a; mwd[m] = d; mbe[m] = 4'(m + 3);
    while (!done && n < 40) begin
      @(negedge clk);
      if ((m == 0 ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
        done = 1;
        gorder.push_back(m);
        chk("xfer_addr", s_address, a);
        chk("xfer_cmd", {s_write, s_read}, wr ? 2'b10 : 2'b01);
      end
      nxt();
      n++;
    end
    chk("xfer_done", done, 1);
    mw[m] = 0; mr[m] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single write: command one cycle after the request, one-cycle waitrequest low.
    mw[0] = 1; ma[0] = 16'h0003; mwd[0] = 32'hdead010a; mbe[0] = 4'hf;
    @(negedge clk);
    chk("sw_decide_cmd", s_write, 0);
    chk("sw_decide_wait", m0_waitrequest, 1);
    nxt(); @(negedge clk);
    chk("sw_s_write", s_write, 1);
    chk("sw_addr", s_address, 16'h0003);
    chk("sw_wdata", s_writedata, 32'hdead010a);
    chk("sw_waits", {m1_waitrequest, m0_waitrequest}, 2'b10);
    nxt(); mw[0] = 0; @(negedge clk);
    chk("sw_after", {s_write, m0_waitrequest}, 2'b01);

    // Contention: two writes each, back to back, alternate grants.
    do_reset();
    fork
      begin xfer(0, 1, 16'h0100, 32'ha0); xfer(0, 1, 16'h0101, 32'ha1); end
      begin xfer(1, 1, 16'h0200, 32'hb0); xfer(1, 1, 16'h0201, 32'hb1); end
    join
    chk("rr_cnt", gorder.size(), 4);
    if (gorder.size() == 4)
      chk("rr_order", {gorder[0][3:0], gorder[1][3:0], gorder[2][3:0], gorder[3][3:0]}, 16'h0101);

    // Slave stall during an m1 read; m0 arrives later and must wait.
    do_reset();
    s_waitrequest = 1;
    fork
      xfer(1, 0, 16'h0007, 32'h0);
      begin nxt(); xfer(0, 1, 16'h0009, 32'h99); end
      begin
        nxt();
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("st_m1_wait", m1_waitrequest, 1);
          chk("st_addr", s_address, 16'h0007);
          chk("st_s_read", s_read, 1);
          chk("st_m0_wait", m0_waitrequest, 1);
          nxt();
        end
        s_waitrequest = 0;
      end
    join
    chk("st_order", (gorder.size() == 2) ? {gorder[0][3:0], gorder[1][3:0]} : 8'hff, 8'h10);

    // Read routing: m0 then m1 read, slave returns late in order.
    do_reset();
    xfer(0, 0, 16'h0003, 32'h0);
    @(negedge clk); chk("rr_pend1", pending_cnt, 1);
    xfer(1, 0, 16'h0001, 32'h0);
    @(negedge clk); chk("rr_pend2", pending_cnt, 2);
    nxt(); s_readdatavalid = 1; s_readdata = 32'h11;
    @(negedge clk);
    chk("rt_m0_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
    chk("rt_m0_data", m0_readdata, 32'h11);
    nxt(); s_readdatavalid = 0;
    @(negedge clk); chk("rt_pend3", pending_cnt, 1);
    nxt(); s_readdatavalid = 1; s_readdata = 32'h22;
    @(negedge clk);
    chk("rt_m1_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
    chk("rt_m1_data", m1_readdata, 32'h22);
    nxt(); s_readdatavalid = 0;
    @(negedge clk); chk("rt_pend4", pending_cnt, 0);

    // FIFO full: four reads outstanding, fifth held, m1 write still goes.
    do_reset();
    for (int i = 0; i < 4; i++) xfer(0, 0, 16'(16'h10 + i), 32'h0);
    @(negedge clk); chk("ff_pend_full", pending_cnt, 4);
    nxt();
    gorder.delete();
    fork
      xfer(0, 0, 16'h0020, 32'h0);
      xfer(1, 1, 16'h0030, 32'hc0ffee00);
      begin
        for (int i = 0; i < 3; i++) nxt();
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          chk("ff_hold_sread", s_read, 0);
          chk("ff_hold_wait", m0_waitrequest, 1);
          chk("ff_hold_pend", pending_cnt, 4);
          nxt();
        end
        s_readdatavalid = 1; s_readdata = 32'h55;
        @(negedge clk);
        chk("ff_pop_rdv", m0_readdatavalid, 1);
        chk("ff_pop_sread", s_read, 0);
        nxt(); s_readdatavalid = 0;
        @(negedge clk);
        chk("ff_release", {s_read, m0_waitrequest}, 2'b10);
      end
    join
    @(negedge clk); chk("ff_pend_after", pending_cnt, 4);
    chk("ff_order", (gorder.size() == 2) ? {gorder[0][3:0], gorder[1][3:0]} : 8'hff, 8'h10);

    // Unexpected readdatavalid: sticky error, no routing; reset clears it.
    do_reset();
    s_readdatavalid = 1; s_readdata = 32'h99;
    @(negedge clk);
    chk("er_no_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
    chk("er_not_yet", err_unexp_rdv, 0);
    nxt(); s_readdatavalid = 0;
    @(negedge clk); chk("er_set", err_unexp_rdv, 1);
    nxt(); nxt();
    @(negedge clk); chk("er_sticky", err_unexp_rdv, 1);
    do_reset();
    @(negedge clk); chk_reset_outs("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/demo_avalon_arbiter_2m.md
Name: demo_avalon_arbiter_2m

Overview:
- Two-master round-robin arbiter sharing one demo Avalon-MM memory slave.
- Each transfer owns the slave bus until the slave accepts it (waitrequest low).
- Pipelined reads are tracked in a tag FIFO, so each readdatavalid is routed back to the master that issued the read.
- Sits between two Avalon-MM masters (CPU bridge, DMA) and the slave's avs_* port.

Parameters:
- AV_ADDRESS_W, 16, address width, shared by masters and slave.
- AV_DATA_W, 32, data width.
- AV_NUMSYMBOLS, 4, byteenable width.
- MAX_PENDING, 4, depth of the outstanding-read tag FIFO; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_write, m0_read  in  1 each  master 0 command strobes.
- m0_address  in  AV_ADDRESS_W  master 0 address.
- m0_byteenable  in  AV_NUMSYMBOLS  master 0 byte enables.
- m0_writedata  in  AV_DATA_W  master 0 write data.
- m0_waitrequest  out  1  stall to master 0.
- m0_readdata  out  AV_DATA_W  read data to master 0.
- m0_readdatavalid  out  1  read data valid to master 0.
- m1_*  same set as m0_*  master 1.
- s_write, s_read  out  1 each  slave command strobes.
- s_address  out  AV_ADDRESS_W  slave address.
- s_byteenable  out  AV_NUMSYMBOLS  slave byte enables.
- s_writedata  out  AV_DATA_W  slave write data.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  AV_DATA_W  slave read data.
- s_readdatavalid  in  1  slave read data valid.
- pending_cnt  out  log2(MAX_PENDING)+1  number of reads outstanding.
- err_unexp_rdv  out  1  sticky: s_readdatavalid arrived with no read outstanding.

Behaviour:
- Request: reqX = mX_write | mX_read. If both strobes are high, the write wins and the read is ignored.
- FSM states:
  - IDLE: both mX_waitrequest=1; s_write=s_read=0.
    - If any request is pending, grant the master that did not win last time (round-robin on last_grant). A lone requester is granted directly.
    - Next state GNT0 or GNT1. Nothing is forwarded in the decision cycle.
  - GNTx:
    - s_address, s_byteenable and s_writedata come from master x; s_write = mX_write.
    - s_read = mX_read & !mX_write & !fifo_full.
    - mX_waitrequest = s_waitrequest | (read & fifo_full). The other master's waitrequest=1.
    - Accepted = (s_write|s_read) & !s_waitrequest. On accept: record last_grant=x, push tag x if it was a read, go to IDLE.
    - If reqX drops while granted (protocol violation), go to IDLE with no transfer and leave last_grant unchanged.
- Latency:
  - Request seen in IDLE at cycle N; command on the slave at N+1.
  - With s_waitrequest=0 it is accepted at N+1, and mX_waitrequest is low at N+1 only.
  - FSM returns to IDLE at N+2. Peak throughput is one transfer per 2 cycles.
- Read return:
  - s_readdata is fanned out to both mX_readdata.
  - On s_readdatavalid with the FIFO non-empty: assert m<head>_readdatavalid in the same cycle (combinational), then pop.
  - A push and a pop in the same cycle are allowed; pending_cnt is unchanged.
  - Full FIFO (pending_cnt==MAX_PENDING): reads are stalled as above; writes still proceed.
  - Empty FIFO with s_readdatavalid: no mX_readdatavalid is asserted and err_unexp_rdv is set; it clears only on reset.
- Reset:
  - FSM goes to IDLE, last_grant=1 (master 0 wins the first tie), FIFO empty, pending_cnt=0, err_unexp_rdv=0.
  - Reset outputs: mX_waitrequest=1, mX_readdatavalid=0, s_write=s_read=0, s_address/s_byteenable/s_writedata=0.
  - A reset mid-transfer aborts it. Reads in flight are discarded; any readdatavalid arriving after reset sets err_unexp_rdv.
- FIFO pointers are log2(MAX_PENDING) bits and wrap naturally; the count is a separate register.

Test Plan:
- Single write: m0 writes 0xdead010a to 0x0003, s_waitrequest=0.
  - s_write=1 with address 0x0003 exactly one cycle after the request.
  - m0_waitrequest low for that one cycle; m1_waitrequest stays 1.
- Contention: m0 and m1 both request writes in the same cycle, each holding its request until accepted.
  - Order m0, m1, m0, m1 over 4 transfers (8 cycles).
  - last_grant alternates 0/1.
- Slave stall: s_waitrequest held high for 3 cycles during an m1 read of 0x0007.
  - m1_waitrequest follows it; address stays stable.
  - m0's request is not granted until m1 is accepted.
- Read routing: m0 reads 0x0003, m1 reads 0x0001; slave returns 0x11, then 0x22, both late.
  - m0_readdatavalid with 0x11, then m1_readdatavalid with 0x22.
  - pending_cnt goes 1, 2, 1, 0.
- FIFO full: MAX_PENDING=4, slave never returns data; m0 issues 5 reads.
  - 5th read held with m0_waitrequest=1 and s_read=0; m1 writes still complete.
  - One s_readdatavalid then lets the 5th read issue.
- Errors: s_readdatavalid pulsed with FIFO empty sets err_unexp_rdv=1 with no mX_readdatavalid. A later reset clears it and returns all outputs to their reset values.
